uart_tx_ctrl: RTL and testbench

- Frame sequencer for the UART transmit path.
- Accepts one byte per valid/ready handshake and serialises it onto the tx line as start, data, optional parity and stop bits.
- Bit boundaries are paced by the one-cycle baud_tick pulse from the baud generator, one tick per bit period.
- Sits between the bridge's TX buffer/register interface and the UART pin.

---
 rtl/uart_pkg.sv | 25 ++
 rtl/uart_tx_ctrl.sv | 168 ++++++++++++++++
 tb/tb_uart_tx_ctrl.sv | 268 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared encodings for the UART transmit path: FSM states, data-bit widths, parity modes.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ALIGN  = 3'd1,
    START  = 3'd2,
    DATA   = 3'd3,
    PARITY = 3'd4,
    STOP   = 3'd5
  } state_t;

  typedef enum logic [1:0] {
    DBITS_5 = 2'd0,
    DBITS_6 = 2'd1,
    DBITS_7 = 2'd2,
    DBITS_8 = 2'd3
  } dbits_t;

  localparam logic PARITY_EVEN = 1'b0;
  localparam logic PARITY_ODD  = 1'b1;

  localparam int MIN_DATA_BITS = 5;

endpackage

// File: rtl/uart_tx_ctrl.sv
// UART transmit frame sequencer: start, 5-8 data bits LSB first, optional parity, 1 or 2 stop bits,
// each bit paced by one baud_tick.
//
// state  | meaning
// IDLE   | line high, ready for a byte
// ALIGN  | byte latched, line high until the next tick starts the start bit
// START  | start bit (0) on the line
// DATA   | data bit bit_cnt on the line
// PARITY | parity bit on the line
// STOP   | stop bit(s) on the line, stop_cnt counts the second one
module uart_tx_ctrl
  import uart_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              baud_tick,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  input  logic [1:0]        cfg_data_bits,
  input  logic              cfg_parity_en,
  input  logic              cfg_parity_odd,
  input  logic              cfg_stop2,
  output logic              tx,
  output logic              busy,
  output logic              tx_done
);

  state_t            state_q, state_d;
  logic              tx_q, tx_d;
  logic [2:0]        bit_cnt_q, bit_cnt_d;
  logic              stop_cnt_q, stop_cnt_d;
  logic              done_q, done_d;
  logic [DATA_W-1:0] data_q, data_d;
  dbits_t            dbits_q, dbits_d;
  logic              par_en_q, par_en_d;
  logic              par_odd_q, par_odd_d;
  logic              stop2_q, stop2_d;

  logic [2:0]        last_idx;
  logic [2:0]        bit_inc;

  // Parity only covers the active data bits; bits above the frame width are masked off.
  function automatic logic frame_parity(input logic [DATA_W-1:0] d, input dbits_t db,
                                        input logic mode);
    logic p;
    p = (mode == PARITY_ODD);
    for (int i = 0; i < DATA_W; i++) begin
      if (i < MIN_DATA_BITS + int'(db)) p = p ^ d[i];
    end
    return p;
  endfunction

  assign last_idx = 3'd4 + {1'b0, dbits_q};
  assign bit_inc  = bit_cnt_q + 3'd1;

  always_comb begin
    state_d    = state_q;
    tx_d       = tx_q;
    bit_cnt_d  = bit_cnt_q;
    stop_cnt_d = stop_cnt_q;
    done_d     = 1'b0;
    data_d     = data_q;
    dbits_d    = dbits_q;
    par_en_d   = par_en_q;
    par_odd_d  = par_odd_q;
    stop2_d    = stop2_q;

    unique case (state_q)
      IDLE: begin
        tx_d = 1'b1;
        if (tx_valid) begin
          data_d    = tx_data;
          dbits_d   = dbits_t'(cfg_data_bits);
          par_en_d  = cfg_parity_en;
          par_odd_d = cfg_parity_odd;
          stop2_d   = cfg_stop2;
          state_d   = ALIGN;
        end
      end
      ALIGN: begin
        if (baud_tick) begin
          tx_d    = 1'b0;
          state_d = START;
        end
      end
      START: begin
        if (baud_tick) begin
          tx_d      = data_q[0];
          bit_cnt_d = 3'd0;
          state_d   = DATA;
        end
      end
      DATA: begin
        if (baud_tick) begin
          if (bit_cnt_q == last_idx) begin
            if (par_en_q) begin
              tx_d    = frame_parity(data_q, dbits_q, par_odd_q);
              state_d = PARITY;
            end else begin
              tx_d       = 1'b1;
              stop_cnt_d = 1'b0;
              state_d    = STOP;
            end
          end else begin
            bit_cnt_d = bit_inc;
            tx_d      = data_q[bit_inc];
          end
        end
      end
      PARITY: begin
        if (baud_tick) begin
          tx_d       = 1'b1;
          stop_cnt_d = 1'b0;
          state_d    = STOP;
        end
      end
      STOP: begin
        if (baud_tick) begin
          if (stop2_q && !stop_cnt_q) begin
            stop_cnt_d = 1'b1;
          end else begin
            done_d  = 1'b1;
            state_d = IDLE;
          end
        end
      end
      default: begin
        tx_d    = 1'b1;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q    <= IDLE;
      tx_q       <= 1'b1;
      bit_cnt_q  <= 3'd0;
      stop_cnt_q <= 1'b0;
      done_q     <= 1'b0;
      data_q     <= '0;
      dbits_q    <= DBITS_5;
      par_en_q   <= 1'b0;
      par_odd_q  <= PARITY_EVEN;
      stop2_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      tx_q       <= tx_d;
      bit_cnt_q  <= bit_cnt_d;
      stop_cnt_q <= stop_cnt_d;
      done_q     <= done_d;
      data_q     <= data_d;
      dbits_q    <= dbits_d;
      par_en_q   <= par_en_d;
      par_odd_q  <= par_odd_d;
      stop2_q    <= stop2_d;
    end
  end

  assign tx       = tx_q;
  assign tx_ready = (state_q == IDLE);
  assign busy     = (state_q != IDLE);
  assign tx_done  = done_q;

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Directed and randomized frames checked tick-by-tick against a bit-list model of the UART frame.
module tb_uart_tx_ctrl;

  logic       clk = 1'b0;
  logic       resetn;
  logic       baud_tick;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic [1:0] cfg_data_bits;
  logic       cfg_parity_en;
  logic       cfg_parity_odd;
  logic       cfg_stop2;
  logic       tx;
  logic       busy;
  logic       tx_done;

  uart_tx_ctrl #(.DATA_W(8)) dut (
    .clk            (clk),
    .resetn         (resetn),
    .baud_tick      (baud_tick),
    .tx_data        (tx_data),
    .tx_valid       (tx_valid),
    .tx_ready       (tx_ready),
    .cfg_data_bits  (cfg_data_bits),
    .cfg_parity_en  (cfg_parity_en),
    .cfg_parity_odd (cfg_parity_odd),
    .cfg_stop2      (cfg_stop2),
    .tx             (tx),
    .busy           (busy),
    .tx_done        (tx_done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int period = 4;
  int tick_phase = 0;
  bit tick_en = 1'b1;
  bit exp_bits[$];
  int last_len = 0;
  int start_cycle = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic drive_tick();
    baud_tick = tick_en && (tick_phase == period - 1);
    if (tick_en) tick_phase = (tick_phase + 1) % period;
  endtask

  // Line level after each successive tick: start, data LSB first, parity, stop bit(s).
  task automatic build_frame(input logic [7:0] d, input logic [1:0] db, input bit pe,
                             input bit po, input bit s2);
    int n;
    int ones;
    n = 5 + int'(db);
    ones = 0;
    exp_bits.delete();
    exp_bits.push_back(1'b0);
    for (int i = 0; i < n; i++) begin
      exp_bits.push_back(d[i]);
      ones += int'(d[i]);
    end
    if (pe) exp_bits.push_back(po ? (ones % 2 == 0) : (ones % 2 == 1));
    exp_bits.push_back(1'b1);
    if (s2) exp_bits.push_back(1'b1);
    last_len = exp_bits.size();
  endtask

  task automatic run_frame(input logic [7:0] d, input logic [1:0] db, input bit pe, input bit po,
                           input bit s2, input bit keep_valid, input bit tick_acc,
                           input bit scramble, input int flip_at);
    int k;
    int guard;
    bit t;
    bit flipped;
    k = 0;
    guard = 0;
    flipped = 1'b0;
    build_frame(d, db, pe, po, s2);
    chk("ready_idle", tx_ready, 1);
    tx_data = d;
    cfg_data_bits = db;
    cfg_parity_en = pe;
    cfg_parity_odd = po;
    cfg_stop2 = s2;
    tx_valid = 1'b1;
    if (tick_acc) baud_tick = 1'b1;
    else drive_tick();
    cycle();
    if (!keep_valid) tx_valid = 1'b0;
    chk("accept_busy", busy, 1);
    chk("accept_tx", tx, 1);
    chk("accept_ready", tx_ready, 0);
    while (k <= last_len && guard < 4000) begin
      if (scramble) begin
        tx_data = 8'($urandom);
        cfg_data_bits = 2'($urandom);
        cfg_parity_en = 1'($urandom);
        cfg_parity_odd = 1'($urandom);
        cfg_stop2 = 1'($urandom);
      end
      if (k == flip_at && !flipped) begin
        cfg_parity_en = ~cfg_parity_en;
        flipped = 1'b1;
      end
      drive_tick();
      t = baud_tick;
      cycle();
      guard++;
      if (t) k++;
      if (k == 0) begin
        chk("align_tx", tx, 1);
        chk("align_busy", busy, 1);
        chk("align_done", tx_done, 0);
      end else if (k <= last_len) begin
        chk("frame_tx", tx, exp_bits[k-1]);
        chk("frame_busy", busy, 1);
        chk("frame_done", tx_done, 0);
        if (k == 1 && t) start_cycle = cyc;
      end else begin
        chk("end_tx", tx, 1);
        chk("end_busy", busy, 0);
        chk("end_done", tx_done, 1);
        chk("end_ready", tx_ready, 1);
      end
    end
    checks++;
    assert (guard < 4000) else begin
      errors++;
      $error("FAIL frame_timeout observed %0d expected below %0d", guard, 4000);
    end
  endtask

  initial begin
    int k;
    int guard;
    int s1;
    int len1;
    bit t;

    resetn = 1'b0;
    baud_tick = 1'b0;
    tx_data = 8'h00;
    tx_valid = 1'b0;
    cfg_data_bits = 2'd3;
    cfg_parity_en = 1'b0;
    cfg_parity_odd = 1'b0;
    cfg_stop2 = 1'b0;
    cycle();
    cycle();
    chk("rst_tx", tx, 1);
    chk("rst_ready", tx_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_done", tx_done, 0);
    resetn = 1'b1;
    cycle();

    // 8N1 0xA5, 7E1 0x53, 5O2 0xFF
    period = 4; tick_phase = 0;
    run_frame(8'hA5, 2'd3, 0, 0, 0, 0, 0, 0, -1);
    cycle();
    run_frame(8'h53, 2'd2, 1, 0, 0, 0, 0, 0, -1);
    cycle();
    run_frame(8'hFF, 2'd0, 1, 1, 1, 0, 0, 0, -1);
    cycle();

    // back-to-back with tx_valid held high
    tick_phase = 0;
    run_frame(8'h00, 2'd3, 0, 0, 0, 1, 0, 0, -1);
    s1 = start_cycle;
    len1 = last_len;
    run_frame(8'hFF, 2'd3, 0, 0, 0, 0, 0, 0, -1);
    chk("b2b_gap", start_cycle - s1, (len1 + 1) * period);
    cycle();

    // parity enable flipped during DATA must not affect the running frame
    run_frame(8'h0F, 2'd3, 0, 0, 0, 0, 0, 0, 4);
    cycle();
    run_frame(8'h0F, 2'd3, 1, 0, 0, 0, 0, 0, -1);
    cycle();

    // tick in the accept cycle is ignored
    tick_phase = 0;
    run_frame(8'h96, 2'd3, 1, 1, 0, 0, 1, 0, -1);
    cycle();

    // reset pulse during DATA aborts the frame
    tick_phase = 0;
    tx_data = 8'h3C; cfg_data_bits = 2'd3; cfg_parity_en = 1'b0; cfg_stop2 = 1'b0;
    tx_valid = 1'b1;
    drive_tick();
    cycle();
    tx_valid = 1'b0;
    k = 0; guard = 0;
    while (k < 4 && guard < 100) begin
      drive_tick();
      t = baud_tick;
      cycle();
      guard++;
      if (t) k++;
    end
    chk("mid_busy", busy, 1);
    resetn = 1'b0;
    drive_tick();
    cycle();
    chk("abort_tx", tx, 1);
    chk("abort_busy", busy, 0);
    chk("abort_ready", tx_ready, 1);
    chk("abort_done", tx_done, 0);
    resetn = 1'b1;
    repeat (12) begin
      drive_tick();
      cycle();
      chk("post_abort_tx", tx, 1);
      chk("post_abort_done", tx_done, 0);
    end

    // no baud ticks: frame waits with the line high
    tick_en = 1'b0;
    baud_tick = 1'b0;
    tx_data = 8'h00;
    tx_valid = 1'b1;
    cycle();
    tx_valid = 1'b0;
    repeat (60) begin
      drive_tick();
      cycle();
      chk("stall_busy", busy, 1);
      chk("stall_tx", tx, 1);
      chk("stall_ready", tx_ready, 0);
    end
    resetn = 1'b0;
    cycle();
    resetn = 1'b1;
    tick_en = 1'b1;
    tick_phase = 0;
    cycle();

    // randomized frames, tick rates and config churn during frames
    for (int f = 0; f < 24; f++) begin
      period = $urandom_range(1, 5);
      tick_phase = 0;
      run_frame(8'($urandom), 2'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                1'($urandom), 1'($urandom), 1'($urandom), -1);
    end
    tx_valid = 1'b0;
    cycle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
